// File: rtl/remote_pos_multi_ch_unpacker_pkg.sv
// Field layout constants and sub-packet struct for the multi-link remote-position unpacker.
package remote_pos_multi_ch_unpacker_pkg;

  localparam int OFFSET_WIDTH            = 27;
  localparam int OFFSET_PAD_W            = 32 - OFFSET_WIDTH;
  localparam int NB_CELL_COUNT_WIDTH     = 5;
  localparam int GLOBAL_CELL_ID_WIDTH    = 3;
  localparam int ELEMENT_WIDTH           = 2;
  localparam int PARID_WIDTH             = 12;
  localparam int OFFSET_PKT_STRUCT_WIDTH = PARID_WIDTH + ELEMENT_WIDTH + 3 * OFFSET_WIDTH;

  localparam int SUB_PKT_W            = 128;
  localparam int SUB_PKT_LAST_BIT     = 96;
  localparam int SUB_PKT_LIFETIME_LSB = 97;
  localparam int SUB_PKT_GCID_LSB     = SUB_PKT_LIFETIME_LSB + NB_CELL_COUNT_WIDTH;
  localparam int SUB_PKT_ELEM_LSB     = SUB_PKT_GCID_LSB + 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int SUB_PKT_PARID_LSB    = SUB_PKT_ELEM_LSB + ELEMENT_WIDTH;
  localparam int SUB_PKT_RSVD_W       = SUB_PKT_W - 1 - (SUB_PKT_PARID_LSB + PARID_WIDTH);

  // MSB-first mirror of the sub-packet layout; top bit is the slot-occupied flag.
  typedef struct packed {
    logic                                  slot_vld;
    logic [SUB_PKT_RSVD_W-1:0]             rsvd;
    logic [PARID_WIDTH-1:0]                parid;
    logic [ELEMENT_WIDTH-1:0]              element;
    logic [3*GLOBAL_CELL_ID_WIDTH-1:0]     gcid;
    logic [NB_CELL_COUNT_WIDTH-1:0]        lifetime;
    logic                                  last;
    logic [OFFSET_PAD_W-1:0]               pad_z;
    logic [OFFSET_WIDTH-1:0]               offset_z;
    logic [OFFSET_PAD_W-1:0]               pad_y;
    logic [OFFSET_WIDTH-1:0]               offset_y;
    logic [OFFSET_PAD_W-1:0]               pad_x;
    logic [OFFSET_WIDTH-1:0]               offset_x;
  } sub_pkt_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/remote_pos_multi_ch_unpacker_if.sv
// Link-side AXIS and ring-side bundle for the unpacker; REMOTE_UNPACK_STATS_EN adds the counters.
interface remote_pos_multi_ch_unpacker_if
  import remote_pos_multi_ch_unpacker_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int NUM_SUB = 4,
  parameter int SUB_W   = 128
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH*NUM_SUB*SUB_W-1:0]      i_tdata;
  logic [NUM_CH-1:0]                    i_tvalid;
  logic [NUM_CH-1:0]                    o_tready;
  logic                                 i_ring_ack;
  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]   o_offset_pkt;
  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]    o_gcid;
  logic [NB_CELL_COUNT_WIDTH-1:0]       o_lifetime;
  logic                                 o_last;
  logic [CH_W-1:0]                      o_src_ch;
  logic                                 o_valid;
`ifdef REMOTE_UNPACK_STATS_EN
  logic [31:0]                          o_sub_count;
  logic [31:0]                          o_drop_count;

  modport slave (
    input  i_tdata, i_tvalid, i_ring_ack,
    output o_tready, o_offset_pkt, o_gcid, o_lifetime, o_last, o_src_ch, o_valid,
    output o_sub_count, o_drop_count
  );
  modport master (
    output i_tdata, i_tvalid, i_ring_ack,
    input  o_tready, o_offset_pkt, o_gcid, o_lifetime, o_last, o_src_ch, o_valid,
    input  o_sub_count, o_drop_count
  );
`else
  modport slave (
    input  i_tdata, i_tvalid, i_ring_ack,
    output o_tready, o_offset_pkt, o_gcid, o_lifetime, o_last, o_src_ch, o_valid
  );
  modport master (
    output i_tdata, i_tvalid, i_ring_ack,
    input  o_tready, o_offset_pkt, o_gcid, o_lifetime, o_last, o_src_ch, o_valid
  );
`endif

endinterface

// File: rtl/remote_pos_multi_ch_unpacker_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, with wrap.
module remote_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (en && !any && req[c]) begin
        grant[c] = 1'b1;
        idx      = CH_W'(c);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/remote_pos_multi_ch_unpacker.sv
// Round-robin multi-link unpacker feeding occupied sub-packets to the position ring one per ack.
// Optional counters are built when REMOTE_UNPACK_STATS_EN is defined.
module remote_pos_multi_ch_unpacker
  import remote_pos_multi_ch_unpacker_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int NUM_SUB      = 4,
  parameter int SUB_W        = 128,
  parameter int SLOT_VLD_BIT = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  remote_pos_multi_ch_unpacker_if.slave bus
);

  localparam int WORD_W    = NUM_SUB * SUB_W;
  localparam int CH_W      = ch_width(NUM_CH);
  localparam int SUB_IDX_W = $clog2(NUM_SUB);

  logic [WORD_W-1:0]    word_reg;
  logic [NUM_SUB-1:0]   mask_reg;
  logic [CH_W-1:0]      cur_ch_reg;
  logic [CH_W-1:0]      rr_ptr_reg;

  logic [SUB_W-1:0]     slots [NUM_SUB];
  logic [SUB_IDX_W-1:0] sel;
  logic                 valid;
  logic                 single;
  logic                 load_ok;
  logic [NUM_CH-1:0]    grant;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [WORD_W-1:0]    grant_word;
  logic [NUM_SUB-1:0]   grant_mask;
  logic [CH_W-1:0]      next_ptr;
  sub_pkt_t             cur_pkt;
  logic                 unused_bits;

  assign valid   = |mask_reg;
  assign single  = valid && ((mask_reg & (mask_reg - NUM_SUB'(1))) == '0);
  // A new word may enter as the last pending slot is acked, which keeps words gapless.
  assign load_ok = !valid || (bus.i_ring_ack && single);

  remote_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (bus.i_tvalid),
    .ptr   (rr_ptr_reg),
    .en    (load_ok && !rst),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign bus.o_tready = grant;
  assign next_ptr     = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

  always_comb begin
    grant_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_idx == CH_W'(c)) grant_word = bus.i_tdata[c*WORD_W +: WORD_W];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_slot
      assign slots[gi]      = word_reg[gi*SUB_W +: SUB_W];
      assign grant_mask[gi] = grant_word[gi*SUB_W + SLOT_VLD_BIT];
    end
  endgenerate

  always_comb begin
    sel = '0;
    for (int s = NUM_SUB - 1; s >= 0; s--) begin
      if (mask_reg[s]) sel = SUB_IDX_W'(s);
    end
  end

  assign cur_pkt     = sub_pkt_t'(slots[sel][SUB_PKT_W-1:0]);
  assign unused_bits = ^{cur_pkt.slot_vld, cur_pkt.rsvd, cur_pkt.pad_z, cur_pkt.pad_y, cur_pkt.pad_x};

  always_comb begin
    bus.o_offset_pkt = '0;
    bus.o_gcid       = '0;
    bus.o_lifetime   = '0;
    bus.o_last       = 1'b0;
    bus.o_src_ch     = '0;
    bus.o_valid      = valid;
    if (valid) begin
      bus.o_offset_pkt = {cur_pkt.parid, cur_pkt.element,
                          cur_pkt.offset_z, cur_pkt.offset_y, cur_pkt.offset_x};
      bus.o_gcid       = cur_pkt.gcid;
      bus.o_lifetime   = cur_pkt.lifetime;
      bus.o_last       = cur_pkt.last;
      bus.o_src_ch     = cur_ch_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg   <= '0;
      mask_reg   <= '0;
      cur_ch_reg <= '0;
      rr_ptr_reg <= '0;
    end else if (load_ok && grant_any) begin
      word_reg   <= grant_word;
      mask_reg   <= grant_mask;
      cur_ch_reg <= grant_idx;
      rr_ptr_reg <= next_ptr;
    end else if (load_ok) begin
      mask_reg <= '0;
    end else if (bus.i_ring_ack) begin
      mask_reg[sel] <= 1'b0;
    end
  end

`ifdef REMOTE_UNPACK_STATS_EN
  logic [31:0] sub_count_reg;
  logic [31:0] drop_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (valid && bus.i_ring_ack && (sub_count_reg != '1))
        sub_count_reg <= sub_count_reg + 32'd1;
      if (load_ok && grant_any && (grant_mask == '0) && (drop_count_reg != '1))
        drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign bus.o_sub_count  = sub_count_reg;
  assign bus.o_drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_remote_pos_multi_ch_unpacker.sv
// Directed bench for remote_pos_multi_ch_unpacker (2 links, 4 slots, 128-bit sub-packets).
module tb_remote_pos_multi_ch_unpacker;

  localparam int NUM_CH  = 2;
  localparam int NUM_SUB = 4;
  localparam int SUB_W   = 128;
  localparam int WORD_W  = NUM_SUB * SUB_W;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  remote_pos_multi_ch_unpacker_if #(.NUM_CH(NUM_CH), .NUM_SUB(NUM_SUB), .SUB_W(SUB_W)) bus ();

  remote_pos_multi_ch_unpacker #(
    .NUM_CH(NUM_CH), .NUM_SUB(NUM_SUB), .SUB_W(SUB_W), .SLOT_VLD_BIT(127)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_sub(input int id, input bit vld);
    logic [127:0] p;
    p           = '0;
    p[26:0]     = 27'(id * 3 + 1);
    p[58:32]    = 27'(id + 1000);
    p[90:64]    = 27'(id * 5 + 7);
    p[96]       = id[0];
    p[101:97]   = 5'(id + 2);
    p[110:102]  = 9'(id * 7);
    p[112:111]  = 2'(id);
    p[124:113]  = 12'(id + 10);
    p[127]      = vld;
    return p;
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input int base, input logic [3:0] m);
    logic [WORD_W-1:0] w;
    for (int s = 0; s < NUM_SUB; s++) w[s*SUB_W +: SUB_W] = mk_sub(base + s, m[s]);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_sub(input string tag, input int id, input int ch);
    logic [94:0] exp_off;
    logic [14:0] exp_misc;
    exp_off  = {12'(id + 10), 2'(id), 27'(id * 5 + 7), 27'(id + 1000), 27'(id * 3 + 1)};
    exp_misc = {9'(id * 7), 5'(id + 2), id[0]};
    check_eq({tag, ".valid"}, bus.o_valid, 1'b1);
    check_eq({tag, ".offset"}, bus.o_offset_pkt, exp_off);
    check_eq({tag, ".misc"}, {bus.o_gcid, bus.o_lifetime, bus.o_last}, exp_misc);
    check_eq({tag, ".src_ch"}, bus.o_src_ch, ch);
    $display("%s sub id=%0d ch=%0d offset=%0h", tag, id, ch, bus.o_offset_pkt);
  endtask

  initial begin
    logic [1:0] tr;
    int cnt [NUM_CH];
    int k_sub, k_grant, gaps, w, ch, id;
    bit started;

    checks   = 0;
    failures = 0;

    // Reset: tready must stay low even with a link requesting.
    rst            = 1'b1;
    bus.i_tdata    = '0;
    bus.i_tvalid   = 2'b01;
    bus.i_ring_ack = 1'b1;
    step();
    step();
    settle();
    check_eq("rst_tready", bus.o_tready, 2'b00);
    check_eq("rst_valid", bus.o_valid, 1'b0);
    check_eq("rst_offset", bus.o_offset_pkt, '0);
    bus.i_tvalid = 2'b00;
    rst          = 1'b0;
    step();

    // Both links with three words each: grants alternate, 24 gapless sub-packets.
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    k_sub = 0; k_grant = 0; gaps = 0; started = 1'b0;
    for (int cyc = 0; cyc < 60 && k_sub < 24; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt[c] < 3) begin
          bus.i_tdata[c*WORD_W +: WORD_W] = mk_word(c * 100 + cnt[c] * 10, 4'hF);
          bus.i_tvalid[c] = 1'b1;
        end else begin
          bus.i_tvalid[c] = 1'b0;
        end
      end
      settle();
      tr = bus.o_tready;
      if (tr != 2'b00) begin
        check_eq("rr_grant", tr, 2'b01 << (k_grant % 2));
        k_grant++;
      end
      if (bus.o_valid) begin
        started = 1'b1;
        w  = k_sub / 4;
        ch = w % 2;
        id = ch * 100 + (w / 2) * 10 + k_sub % 4;
        expect_sub("rr", id, ch);
        k_sub++;
      end else if (started) begin
        gaps++;
      end
      step();
      for (int c = 0; c < NUM_CH; c++) if (tr[c]) cnt[c]++;
    end
    bus.i_tvalid = 2'b00;
    check_eq("rr_count", k_sub, 24);
    check_eq("rr_grants", k_grant, 6);
    check_eq("rr_gaps", gaps, 0);

    // Single link, all slots valid, ack held high.
    bus.i_tdata[0 +: WORD_W] = mk_word(0, 4'hF);
    bus.i_tvalid = 2'b01;
    settle();
    check_eq("full_tready", bus.o_tready, 2'b01);
    check_eq("full_pre_valid", bus.o_valid, 1'b0);
    step();
    bus.i_tvalid = 2'b00;
    for (int s = 0; s < 4; s++) begin
      settle();
      expect_sub("full", s, 0);
      step();
    end
    settle();
    check_eq("full_done_valid", bus.o_valid, 1'b0);

    // Sparse mask: only slots 1 and 3 are presented, back to back.
    bus.i_tdata[0 +: WORD_W] = mk_word(10, 4'b1010);
    bus.i_tvalid = 2'b01;
    settle();
    check_eq("sparse_tready", bus.o_tready, 2'b01);
    step();
    bus.i_tvalid = 2'b00;
    settle();
    expect_sub("sparse", 11, 0);
    step();
    expect_sub("sparse", 13, 0);
    step();
    check_eq("sparse_done_valid", bus.o_valid, 1'b0);

    // All-zero word on link 1 is popped and dropped.
    bus.i_tdata[WORD_W +: WORD_W] = '0;
    bus.i_tvalid = 2'b10;
    settle();
    check_eq("zero_tready", bus.o_tready, 2'b10);
    check_eq("zero_pre_valid", bus.o_valid, 1'b0);
    step();
    bus.i_tvalid = 2'b00;
    settle();
    check_eq("zero_valid", bus.o_valid, 1'b0);
`ifdef REMOTE_UNPACK_STATS_EN
    check_eq("zero_drop_count", bus.o_drop_count, 32'd1);
`endif

    // Ack stalled for 10 cycles mid-word; a waiting link must not be popped.
    bus.i_tdata[0 +: WORD_W] = mk_word(200, 4'hF);
    bus.i_tvalid = 2'b01;
    settle();
    check_eq("stall_tready", bus.o_tready, 2'b01);
    step();
    bus.i_tvalid = 2'b00;
    settle();
    expect_sub("stall", 200, 0);
    step();
    bus.i_ring_ack = 1'b0;
    bus.i_tdata[WORD_W +: WORD_W] = mk_word(250, 4'hF);
    bus.i_tvalid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      settle();
      expect_sub("hold", 201, 0);
      check_eq("hold_tready", bus.o_tready, 2'b00);
      step();
    end
    bus.i_tvalid   = 2'b00;
    bus.i_ring_ack = 1'b1;
    for (int s = 1; s < 4; s++) begin
      settle();
      expect_sub("resume", 200 + s, 0);
      step();
    end
    check_eq("resume_done_valid", bus.o_valid, 1'b0);

    // Reset with slot 2 pending, then a fresh word starts from link 0 slot 0.
    bus.i_tdata[WORD_W +: WORD_W] = mk_word(300, 4'hF);
    bus.i_tvalid = 2'b10;
    settle();
    check_eq("mid_tready", bus.o_tready, 2'b10);
    step();
    bus.i_tvalid = 2'b00;
    for (int s = 0; s < 3; s++) begin
      settle();
      expect_sub("mid", 300 + s, 1);
      if (s < 2) step();
    end
    rst = 1'b1;
    step();
    bus.i_tdata[0 +: WORD_W]      = mk_word(400, 4'hF);
    bus.i_tdata[WORD_W +: WORD_W] = mk_word(500, 4'hF);
    bus.i_tvalid = 2'b11;
    settle();
    check_eq("mrst_valid", bus.o_valid, 1'b0);
    check_eq("mrst_offset", bus.o_offset_pkt, '0);
    check_eq("mrst_misc", {bus.o_gcid, bus.o_lifetime, bus.o_last}, '0);
    check_eq("mrst_src_ch", bus.o_src_ch, '0);
    check_eq("mrst_tready", bus.o_tready, 2'b00);
    rst = 1'b0;
    settle();
    check_eq("fresh_tready", bus.o_tready, 2'b01);
    step();
    bus.i_tvalid = 2'b00;
    for (int s = 0; s < 4; s++) begin
      settle();
      expect_sub("fresh", 400 + s, 0);
      step();
    end
    check_eq("fresh_done_valid", bus.o_valid, 1'b0);
`ifdef REMOTE_UNPACK_STATS_EN
    check_eq("stats_sub_count", bus.o_sub_count, 32'd4);
    check_eq("stats_drop_count", bus.o_drop_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/remote_pos_multi_ch_unpacker.md
Name: remote_pos_multi_ch_unpacker

Overview:
- Parametrised successor to the single-link remote-position deserializer.
- Accepts wide AXIS words from NUM_CH remote links and selects one link at a time by round-robin.
- Unpacks NUM_SUB sub-packets per word and presents them one at a time to the position ring under a valid/ack handshake.
- Sub-packets whose slot-valid bit is clear are skipped with no ring cycle spent; a word with no valid slots is consumed and dropped.

Parameters:
NUM_CH, 2, number of remote input links.
NUM_SUB, 4, sub-packets per AXIS word (power of two, ≥2).
SUB_W, 128, sub-packet width in bits.
SLOT_VLD_BIT, 127, bit index inside a sub-packet marking the slot as occupied.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
i_tdata  in  NUM_CH*NUM_SUB*SUB_W  per-link AXIS data; link c at [c*NUM_SUB*SUB_W +: NUM_SUB*SUB_W]; sub-packet s at [s*SUB_W +: SUB_W] within it.
i_tvalid  in  NUM_CH  per-link word valid.
o_tready  out  NUM_CH  per-link one-hot accept (combinational, same-cycle pop).
i_ring_ack  in  1  ring consumed current output.
o_offset_pkt  out  OFFSET_PKT_STRUCT_WIDTH  {parid,element,offset_z,offset_y,offset_x}.
o_gcid  out  3*GLOBAL_CELL_ID_WIDTH  home cell id.
o_lifetime  out  NB_CELL_COUNT_WIDTH  remaining hop count.
o_last  out  1  last-transfer flag of current sub-packet.
o_src_ch  out  $clog2(NUM_CH)  link the current sub-packet came from.
o_valid  out  1  output fields valid.

Behaviour:
- Sub-packet field layout, LSB first:
  - x offset at [0 +: OFFSET_WIDTH], y at [32 +:], z at [64 +:].
  - last at bit 96.
  - lifetime at [97 +: NB_CELL_COUNT_WIDTH].
  - gcid next, then element, then parid.
  - Slot-valid flag at SLOT_VLD_BIT.
- Registers:
  - word_reg: NUM_SUB*SUB_W.
  - mask: NUM_SUB bits, one per slot-valid flag.
  - cur_ch: source link of word_reg.
  - rr_ptr: round-robin pointer.
- Outputs are decoded combinationally from slot sel = lowest set bit of mask. o_valid = |mask.
- Load condition, evaluated each cycle: load_ok = ~o_valid OR (i_ring_ack AND mask has exactly one bit set).
- On a load cycle:
  - Grant the first link c with i_tvalid[c], searching from rr_ptr upward with wrap.
  - o_tready[c]=1 in that cycle only.
  - word_reg←i_tdata[c], mask←slot flags, cur_ch←c, rr_ptr←c+1 mod NUM_CH.
- If load_ok and no link is valid: on ack, mask←0 and o_valid falls the next cycle.
- Ack while o_valid and not loading: clear the mask bit at sel. The next occupied slot appears the following cycle; empty slots are skipped with no bubble.
- Ack while ~o_valid: ignored.
- Latency: i_tvalid to o_valid is 1 cycle. Back-to-back words stream gaplessly, one sub-packet per ack cycle.
- All-zero word: popped (tready=1) and dropped; o_valid stays 0 and the next load is tried the next cycle.
- Fairness: with all links continuously valid, grants rotate 0,1,…,NUM_CH-1.
- o_tready is forced 0 during rst.
- Reset: word_reg, mask, cur_ch and rr_ptr clear to 0. Outputs read 0, o_valid=0, o_tready=0. A word in flight is discarded.
- Upstream must keep i_tdata stable while i_tvalid is high and o_tready is low.

Optional Feature:
- Macro REMOTE_UNPACK_STATS_EN.
- Defined, adds two outputs:
  - o_sub_count [31:0]: count of acked sub-packets.
  - o_drop_count [31:0]: count of dropped all-zero words.
  - Both clear on rst and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- MD_pkg gains:
  - SUB_PKT_LAST_BIT, SUB_PKT_LIFETIME_LSB, SUB_PKT_GCID_LSB, SUB_PKT_ELEM_LSB, SUB_PKT_PARID_LSB.
  - A sub_pkt_t packed struct matching the layout.
- One sub-module, remote_rr_arbiter:
  - Inputs: NUM_CH request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- Priority encoder and mask update stay inline.

Test Plan:
- Single link, NUM_SUB=4, all slots valid, ack held high → tready pulses once; o_valid runs for 4 consecutive cycles with slots 0..3 in order, then drops.
- Mask 4'b1010 → exactly 2 outputs (slots 1, 3) on consecutive ack cycles; no cycle is spent on slots 0 and 2.
- Both links valid with 3 words each, ack high → o_src_ch sequence 0,1,0,1,0,1 by word; 24 sub-packets with no idle cycle between words.
- All-zero word on link 1 → o_tready[1] pulses, o_valid stays 0; with stats, o_drop_count=1.
- Ack low for 10 cycles mid-word → outputs held stable, no tready; resume gives the remaining slots in order.
- rst asserted while slot 2 is pending → next cycle o_valid=0, all outputs 0; a fresh word afterwards starts at slot 0 from link 0.
